// File: rtl/prbs_frame_gen.sv
// prbs_frame_gen: Galois LFSR pattern generator that emits a frame of LEN
// pseudo-random words over a valid/ready stream, with abort, done pulse and
// recovery from an all-zero LFSR state.
//
// Stream handshake: a word transfers on every rising clk edge where
// out_valid && out_ready are both high. While out_valid is high and
// out_ready is low, out_data and out_last hold steady. out_valid never
// depends combinationally on out_ready.
module prbs_frame_gen #(
    parameter int             W     = 8,
    parameter logic [W-1:0]   TAPS  = 'h1C,
    parameter logic [W-1:0]   SEED  = 'h20,
    parameter int             STEP  = 1,
    parameter int             LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic             seed_load,
    input  logic [W-1:0]     seed_in,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done,
    output logic             busy,
    output logic [LEN_W-1:0] count,
    output logic             lockup,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               lockup_q, lockup_d;

    logic [W-1:0]       lfsr_adv;
    logic               hs;

    // One Galois shift: MSB feeds bit 0 and is XORed into every tapped bit.
    function automatic logic [W-1:0] lfsr_shift(input logic [W-1:0] s);
        logic [W-1:0] n;
        n[0] = s[W-1];
        for (int i = 1; i < W; i++) begin
            n[i] = s[i-1] ^ (TAPS[i] & s[W-1]);
        end
        return n;
    endfunction

    // STEP chained shifts unrolled into one cycle.
    always_comb begin
        lfsr_adv = lfsr_q;
        for (int k = 0; k < STEP; k++) begin
            lfsr_adv = lfsr_shift(lfsr_adv);
        end
    end

    assign hs = valid_q & out_ready;

    // Next-state for the frame FSM and all registered outputs.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        len_d    = len_q;
        count_d  = count_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        lockup_d = lockup_q;

        case (state_q)
            ST_IDLE: begin
                // A zero seed would lock the LFSR; substitute SEED and flag it.
                if (seed_load) begin
                    if (seed_in == '0) begin
                        lfsr_d   = SEED;
                        lockup_d = 1'b1;
                    end else begin
                        lfsr_d = seed_in;
                    end
                end
                if (start) begin
                    len_d   = len;
                    count_d = '0;
                    if (len != '0) begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                        last_d  = (len == LEN_W'(1));
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort takes priority over a same-cycle handshake: no advance.
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (hs) begin
                    lfsr_d  = lfsr_adv;
                    count_d = count_q + LEN_W'(1);
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        last_d = ((count_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        // Lock-up guard: an all-zero register never survives a clock.
        if (lfsr_q == '0) begin
            lfsr_d   = SEED;
            lockup_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, asynchronously reset to the idle frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            len_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            len_q    <= len_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_data  = lfsr_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign lockup    = lockup_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_prbs_frame_gen.sv
// Bench for prbs_frame_gen: two instances (STEP=1 and STEP=2) driven by
// directed and randomized frames, checked against an arithmetic LFSR model.
module tb_prbs_frame_gen;

    localparam int         W     = 8;
    localparam int         LEN_W = 16;
    localparam logic [7:0] SEED  = 8'h20;
    localparam logic [7:0] TAPS  = 8'h1C;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            start = '0, abort = '0, seed_load = '0, out_ready = '0;
    logic [1:0][LEN_W-1:0] len = '0;
    logic [1:0][W-1:0]     seed_in = '0;
    logic [1:0][W-1:0]     out_data;
    logic [1:0]            out_valid, out_last, done, busy, lockup;
    logic [1:0][LEN_W-1:0] count;
    logic [1:0][1:0]       state_dbg;

    prbs_frame_gen #(.W(W), .TAPS(TAPS), .SEED(SEED), .STEP(1), .LEN_W(LEN_W)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
        .len(len[0]), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .done(done[0]), .busy(busy[0]), .count(count[0]),
        .lockup(lockup[0]), .state_dbg(state_dbg[0])
    );

    prbs_frame_gen #(.W(W), .TAPS(TAPS), .SEED(SEED), .STEP(2), .LEN_W(LEN_W)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
        .len(len[1]), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .done(done[1]), .busy(busy[1]), .count(count[1]),
        .lockup(lockup[1]), .state_dbg(state_dbg[1])
    );

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_lfsr [2];
    logic       m_lock [2];
    int         m_step [2];
    logic [7:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: multiply by x modulo the feedback polynomial, 'steps' times.
    function automatic logic [7:0] m_next(input logic [7:0] s, input int steps);
        int v;
        v = int'(s);
        for (int k = 0; k < steps; k++) begin
            if (v >= 128) v = (v * 2 - 256) ^ int'((TAPS & 8'hFE) | 8'h01);
            else          v = v * 2;
        end
        return v[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk_reset_outputs(input int d);
        chk("rst_data", out_data[d], SEED);
        chk("rst_valid", out_valid[d], 1'b0);
        chk("rst_last", out_last[d], 1'b0);
        chk("rst_done", done[d], 1'b0);
        chk("rst_busy", busy[d], 1'b0);
        chk("rst_count", count[d], 16'd0);
        chk("rst_lockup", lockup[d], 1'b0);
    endtask

    // Assert reset away from any clock edge to show it acts asynchronously.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        start = '0; abort = '0; seed_load = '0; out_ready = '0;
        #1;
        for (int d = 0; d < 2; d++) chk_reset_outputs(d);
        for (int d = 0; d < 2; d++) begin
            m_lfsr[d] = SEED;
            m_lock[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic seed_only(input int d, input logic [7:0] sv);
        @(negedge clk);
        seed_load[d] = 1'b1;
        seed_in[d]   = sv;
        if (sv == 8'h00) begin
            m_lfsr[d] = SEED;
            m_lock[d] = 1'b1;
        end else begin
            m_lfsr[d] = sv;
        end
        @(negedge clk);
        seed_load[d] = 1'b0;
        chk("seed_data", out_data[d], m_lfsr[d]);
        chk("seed_lockup", lockup[d], m_lock[d]);
        chk("seed_idle", busy[d], 1'b0);
    endtask

    // One frame: optional seed load alongside start, optional random stalls,
    // optional abort at word index ab_at (-1 = none).
    task automatic run_frame(input int d, input int n, input bit stall,
                             input int ab_at, input bit ld, input logic [7:0] sv);
        logic [7:0] exp_q[$];
        logic [7:0] s;
        int         acc;
        int         budget;
        int         seen [256];
        int         dups;
        got_q = {};
        for (int i = 0; i < 256; i++) seen[i] = 0;
        @(negedge clk);
        if (ld) begin
            seed_load[d] = 1'b1;
            seed_in[d]   = sv;
            if (sv == 8'h00) begin
                m_lfsr[d] = SEED;
                m_lock[d] = 1'b1;
            end else begin
                m_lfsr[d] = sv;
            end
        end
        start[d] = 1'b1;
        len[d]   = LEN_W'(n);
        s = m_lfsr[d];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(s);
            s = m_next(s, m_step[d]);
        end
        m_lfsr[d] = s;
        @(negedge clk);
        start[d]     = 1'b0;
        seed_load[d] = 1'b0;
        if (n == 0) begin
            chk("len0_done", done[d], 1'b1);
            chk("len0_busy", busy[d], 1'b1);
            chk("len0_valid", out_valid[d], 1'b0);
            @(negedge clk);
            chk("len0_done_clr", done[d], 1'b0);
            chk("len0_idle", busy[d], 1'b0);
            chk("len0_count", count[d], 16'd0);
            return;
        end
        acc = 0;
        budget = 0;
        while (acc < n && budget < 8 * n + 20) begin
            chk("valid", out_valid[d], 1'b1);
            chk("data", out_data[d], exp_q[0]);
            chk("last", out_last[d], acc == n - 1);
            chk("count", count[d], LEN_W'(acc));
            chk("done_low", done[d], 1'b0);
            chk("busy_run", busy[d], 1'b1);
            if (ab_at == acc) begin
                abort[d]     = 1'b1;
                out_ready[d] = 1'b1;
                @(negedge clk);
                abort[d]     = 1'b0;
                out_ready[d] = 1'b0;
                m_lfsr[d]    = exp_q[0];
                chk("abort_valid", out_valid[d], 1'b0);
                chk("abort_busy", busy[d], 1'b0);
                chk("abort_data", out_data[d], exp_q[0]);
                chk("abort_count", count[d], LEN_W'(acc));
                chk("abort_done", done[d], 1'b0);
                @(negedge clk);
                chk("abort_done2", done[d], 1'b0);
                chk("abort_hold", out_data[d], exp_q[0]);
                return;
            end
            out_ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready[d]) begin
                got_q.push_back(out_data[d]);
                seen[out_data[d]]++;
            end
            @(negedge clk);
            budget++;
            if (out_ready[d]) begin
                void'(exp_q.pop_front());
                acc++;
            end
        end
        out_ready[d] = 1'b0;
        chk("handshakes", acc, n);
        if (acc == n) begin
            chk("end_done", done[d], 1'b1);
            chk("end_busy", busy[d], 1'b1);
            chk("end_valid", out_valid[d], 1'b0);
            chk("end_count", count[d], LEN_W'(n));
            @(negedge clk);
            chk("end_done_clr", done[d], 1'b0);
            chk("end_idle", busy[d], 1'b0);
            chk("end_count_hold", count[d], LEN_W'(n));
            chk("end_data", out_data[d], m_lfsr[d]);
            chk("end_lockup", lockup[d], m_lock[d]);
            if (n <= 255) begin
                dups = 0;
                for (int i = 0; i < 256; i++) if (seen[i] > 1) dups++;
                chk("distinct", dups, 0);
                chk("nonzero", seen[0], 0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp1 [5];
        exp1[0] = 8'h20; exp1[1] = 8'h40; exp1[2] = 8'h80; exp1[3] = 8'h1D; exp1[4] = 8'h3A;
        m_step[0] = 1;
        m_step[1] = 2;

        do_reset();

        // abort in IDLE is ignored
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("idle_abort_busy", busy[0], 1'b0);
        chk("idle_abort_valid", out_valid[0], 1'b0);
        chk("idle_abort_data", out_data[0], SEED);

        // first frame from reset, known sequence
        run_frame(0, 5, 1'b0, -1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) chk("seq1", got_q[i], exp1[i]);

        // STEP=2 with seed load alongside start, then continuation
        run_frame(1, 3, 1'b0, -1, 1'b1, 8'h20);
        chk("step2_w0", got_q[0], 8'h20);
        chk("step2_w1", got_q[1], 8'h80);
        chk("step2_w2", got_q[2], 8'h3A);
        run_frame(1, 1, 1'b0, -1, 1'b0, 8'h00);
        chk("step2_cont", got_q[0], 8'hE8);

        // backpressure
        run_frame(0, 20, 1'b1, -1, 1'b0, 8'h00);

        // full period, then wrap back to SEED
        do_reset();
        run_frame(0, 255, 1'b0, -1, 1'b0, 8'h00);
        run_frame(0, 1, 1'b0, -1, 1'b0, 8'h00);
        chk("period_wrap", got_q[0], 8'h20);

        // zero-length frame
        run_frame(1, 0, 1'b0, -1, 1'b0, 8'h00);

        // zero seed recovery; lockup is sticky across a frame
        seed_only(0, 8'h00);
        run_frame(0, 4, 1'b1, -1, 1'b0, 8'h00);

        // abort on word 3 with ready high in the same cycle
        run_frame(0, 8, 1'b0, 3, 1'b0, 8'h00);
        run_frame(0, 3, 1'b0, -1, 1'b0, 8'h00);

        // reset mid-frame
        @(negedge clk);
        start[0] = 1'b1;
        len[0]   = 16'd10;
        @(negedge clk);
        start[0]     = 1'b0;
        out_ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_pre_busy", busy[0], 1'b1);
        do_reset();

        // randomized frames on both instances
        for (int it = 0; it < 12; it++) begin
            for (int d = 0; d < 2; d++) begin
                run_frame(d, $urandom_range(1, 40), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1,
                          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
